// File: rtl/control_sequencer_if.sv
// control_sequencer_if: opcode/flag inputs and control strobe outputs of the microcode sequencer
interface control_sequencer_if #(parameter int OPCODE_WIDTH = 4);
  logic [OPCODE_WIDTH-1:0] i_opcode;
  logic i_flag_c;
  logic i_flag_z;
  logic [2:0] o_step;
  logic o_co, o_ce, o_j, o_mi, o_ro, o_ri, o_io, o_ii;
  logic o_ai, o_ao, o_bi, o_eo, o_su, o_fi, o_oi, o_hlt;
  modport master (
    input  i_opcode, i_flag_c, i_flag_z,
    output o_step, o_co, o_ce, o_j, o_mi, o_ro, o_ri, o_io, o_ii,
    output o_ai, o_ao, o_bi, o_eo, o_su, o_fi, o_oi, o_hlt
  );
  modport slave (
    output i_opcode, i_flag_c, i_flag_z,
    input  o_step, o_co, o_ce, o_j, o_mi, o_ro, o_ri, o_io, o_ii,
    input  o_ai, o_ao, o_bi, o_eo, o_su, o_fi, o_oi, o_hlt
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: five-step microcode sequencer decoding opcode and flags into datapath strobes
module control_sequencer #(
  parameter int OPCODE_WIDTH = 4
) (
  input  logic i_clk,
  input  logic i_clke,
  input  logic i_reset,
  control_sequencer_if.master bus
);
  typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_t;
  step_t step, step_nx;
  logic halted, halted_nx;
  logic op_lda, op_add, op_sub, op_sta, op_ldi, op_jmp, op_jc, op_jz, op_out, op_hlt;
  logic run, t0, t1, t2, t3, t4, alu;
  assign op_lda = bus.i_opcode == OPCODE_WIDTH'(1);
  assign op_add = bus.i_opcode == OPCODE_WIDTH'(2);
  assign op_sub = bus.i_opcode == OPCODE_WIDTH'(3);
  assign op_sta = bus.i_opcode == OPCODE_WIDTH'(4);
  assign op_ldi = bus.i_opcode == OPCODE_WIDTH'(5);
  assign op_jmp = bus.i_opcode == OPCODE_WIDTH'(6);
  assign op_jc  = bus.i_opcode == OPCODE_WIDTH'(7);
  assign op_jz  = bus.i_opcode == OPCODE_WIDTH'(8);
  assign op_out = bus.i_opcode == OPCODE_WIDTH'(14);
  assign op_hlt = bus.i_opcode == OPCODE_WIDTH'(15);
  assign alu = op_add | op_sub;
  // Strobes are gated off during reset and while halted so no datapath write can slip through
  assign run = !i_reset && !halted;
  assign t0 = run && step == T0;
  assign t1 = run && step == T1;
  assign t2 = run && step == T2;
  assign t3 = run && step == T3;
  assign t4 = run && step == T4;
  assign bus.o_step = step;
  assign bus.o_co = t0;
  assign bus.o_mi = t0 | (t2 & (op_lda | alu | op_sta));
  assign bus.o_ro = t1 | (t3 & (op_lda | alu));
  assign bus.o_ii = t1;
  assign bus.o_ce = t1;
  assign bus.o_io = t2 & (op_lda | alu | op_sta | op_ldi | op_jmp | op_jc | op_jz);
  assign bus.o_j  = t2 & (op_jmp | (op_jc & bus.i_flag_c) | (op_jz & bus.i_flag_z));
  assign bus.o_ai = (t2 & op_ldi) | (t3 & op_lda) | (t4 & alu);
  assign bus.o_ao = (t2 & op_out) | (t3 & op_sta);
  assign bus.o_bi = t3 & alu;
  assign bus.o_ri = t3 & op_sta;
  assign bus.o_eo = t4 & alu;
  assign bus.o_su = t4 & op_sub;
  assign bus.o_fi = t4 & alu;
  assign bus.o_oi = t2 & op_out;
  assign bus.o_hlt = !i_reset && (halted || (step == T2 && op_hlt));
  // Next step and halt: reset beats halt beats advance, and nothing moves without i_clke
  always_comb begin
    step_nx = !i_clke ? step
            : i_reset ? T0
            : halted ? step
            : (step == T2 && op_hlt) || step == T4 ? T0
            : step_t'(3'(step + 3'd1));
    halted_nx = !i_clke ? halted : i_reset ? 1'b0 : halted | (step == T2 && op_hlt);
  end
  // State register
  always_ff @(posedge i_clk) begin
    step <= step_nx;
    halted <= halted_nx;
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: vector table, hand sequences and randomized model check of control_sequencer
module tb_control_sequencer;
  localparam logic [14:0] CO = 15'h4000, CE = 15'h2000, J = 15'h1000, MI = 15'h0800;
  localparam logic [14:0] RO = 15'h0400, RI = 15'h0200, IO = 15'h0100, II = 15'h0080;
  localparam logic [14:0] AI = 15'h0040, AO = 15'h0020, BI = 15'h0010, EO = 15'h0008;
  localparam logic [14:0] SU = 15'h0004, FI = 15'h0002, OI = 15'h0001;
  logic clk = 0, clke = 0, rst = 0;
  int checks = 0, errors = 0;
  int m_step = 0;
  bit m_halt = 0;
  control_sequencer_if #(.OPCODE_WIDTH(4)) bus ();
  control_sequencer #(.OPCODE_WIDTH(4)) dut (.i_clk(clk), .i_clke(clke), .i_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    bit r, ce;
    logic [3:0] op;
    bit c, z, chk_step;
    int step;
    logic [14:0] str;
    bit hlt;
  } vec_t;
  vec_t vecs[$];
  logic [14:0] nop_str[5];
  function automatic logic [14:0] strobes();
    return {bus.o_co, bus.o_ce, bus.o_j, bus.o_mi, bus.o_ro, bus.o_ri, bus.o_io, bus.o_ii,
            bus.o_ai, bus.o_ao, bus.o_bi, bus.o_eo, bus.o_su, bus.o_fi, bus.o_oi};
  endfunction
  function automatic logic [14:0] micro(int op, int st, bit c, bit z);
    logic [14:0] t[5];
    t[0] = CO | MI; t[1] = RO | II | CE; t[2] = 0; t[3] = 0; t[4] = 0;
    case (op)
      1: begin t[2] = IO | MI; t[3] = RO | AI; end
      2: begin t[2] = IO | MI; t[3] = RO | BI; t[4] = EO | AI | FI; end
      3: begin t[2] = IO | MI; t[3] = RO | BI; t[4] = EO | AI | FI | SU; end
      4: begin t[2] = IO | MI; t[3] = AO | RI; end
      5: t[2] = IO | AI;
      6: t[2] = IO | J;
      7: t[2] = c ? IO | J : IO;
      8: t[2] = z ? IO | J : IO;
      14: t[2] = AO | OI;
      default: ;
    endcase
    return t[st];
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(bit r, bit ce, logic [3:0] op, bit c, bit z);
    @(negedge clk);
    rst = r; clke = ce; bus.i_opcode = op; bus.i_flag_c = c; bus.i_flag_z = z;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    if (clke) begin
      if (rst) begin m_step = 0; m_halt = 0; end
      else if (!m_halt) begin
        if (m_step == 2 && bus.i_opcode == 4'hF) begin m_halt = 1; m_step = 0; end
        else m_step = (m_step + 1) % 5;
      end
    end
  endtask
  task automatic model_check(string name);
    logic [14:0] e;
    e = (rst || m_halt) ? 15'd0 : micro(int'(bus.i_opcode), m_step, bus.i_flag_c, bus.i_flag_z);
    chk({name, "_step"}, 32'(bus.o_step), 32'(m_step));
    chk({name, "_str"}, 32'(strobes()), 32'(e));
    chk({name, "_hlt"}, 32'(bus.o_hlt), 32'(!rst && (m_halt || (m_step == 2 && bus.i_opcode == 4'hF))));
    chk({name, "_bus1"}, 32'($countones({bus.o_co, bus.o_ro, bus.o_io, bus.o_ao, bus.o_eo}) <= 1), 32'd1);
  endtask
  function automatic vec_t v(bit r, bit ce, int op, bit c, bit z, bit cs, int st, logic [14:0] s, bit h);
    vec_t x;
    x.r = r; x.ce = ce; x.op = 4'(op); x.c = c; x.z = z; x.chk_step = cs; x.step = st; x.str = s; x.hlt = h;
    return x;
  endfunction
  initial begin
    bus.i_opcode = 0; bus.i_flag_c = 0; bus.i_flag_z = 0;
    vecs.push_back(v(1, 1, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 2, 0, 0, 1, 0, CO | MI, 0));
    vecs.push_back(v(0, 1, 2, 0, 0, 1, 1, RO | II | CE, 0));
    vecs.push_back(v(0, 1, 2, 0, 0, 1, 2, IO | MI, 0));
    vecs.push_back(v(0, 1, 2, 0, 0, 1, 3, RO | BI, 0));
    vecs.push_back(v(0, 1, 2, 0, 0, 1, 4, EO | AI | FI, 0));
    vecs.push_back(v(0, 1, 7, 0, 0, 1, 0, CO | MI, 0));
    vecs.push_back(v(0, 1, 7, 0, 0, 1, 1, RO | II | CE, 0));
    vecs.push_back(v(0, 1, 7, 0, 1, 1, 2, IO, 0));
    vecs.push_back(v(0, 1, 7, 1, 0, 1, 3, 0, 0));
    vecs.push_back(v(0, 1, 7, 1, 0, 1, 4, 0, 0));
    vecs.push_back(v(0, 1, 7, 1, 0, 1, 0, CO | MI, 0));
    vecs.push_back(v(0, 1, 7, 1, 0, 1, 1, RO | II | CE, 0));
    vecs.push_back(v(0, 1, 7, 1, 0, 1, 2, IO | J, 0));
    vecs.push_back(v(0, 1, 8, 0, 1, 1, 3, 0, 0));
    vecs.push_back(v(0, 1, 8, 0, 1, 1, 4, 0, 0));
    vecs.push_back(v(0, 1, 8, 0, 1, 1, 0, CO | MI, 0));
    vecs.push_back(v(0, 1, 8, 0, 1, 1, 1, RO | II | CE, 0));
    vecs.push_back(v(0, 1, 8, 0, 1, 1, 2, IO | J, 0));
    vecs.push_back(v(0, 0, 3, 0, 0, 1, 3, RO | BI, 0));
    vecs.push_back(v(1, 0, 3, 0, 0, 1, 3, 0, 0));
    vecs.push_back(v(0, 0, 3, 0, 0, 1, 3, RO | BI, 0));
    vecs.push_back(v(1, 1, 3, 0, 0, 1, 3, 0, 0));
    vecs.push_back(v(0, 1, 3, 0, 0, 1, 0, CO | MI, 0));
    vecs.push_back(v(0, 1, 3, 0, 0, 1, 1, RO | II | CE, 0));
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].ce, vecs[i].op, vecs[i].c, vecs[i].z);
      if (vecs[i].chk_step) chk($sformatf("vec%0d_step", i), 32'(bus.o_step), 32'(vecs[i].step));
      chk($sformatf("vec%0d_str", i), 32'(strobes()), 32'(vecs[i].str));
      chk($sformatf("vec%0d_hlt", i), 32'(bus.o_hlt), 32'(vecs[i].hlt));
      tick();
    end
    drive(1, 1, 15, 0, 0); tick();
    drive(0, 1, 15, 0, 0); chk("hlt_t0", 32'(strobes()), 32'(CO | MI)); tick();
    drive(0, 1, 15, 0, 0); chk("hlt_t1", 32'(strobes()), 32'(RO | II | CE)); tick();
    drive(0, 1, 15, 0, 0);
    chk("hlt_t2_step", 32'(bus.o_step), 2);
    chk("hlt_t2_str", 32'(strobes()), 0);
    chk("hlt_t2_hlt", 32'(bus.o_hlt), 1);
    tick();
    for (int i = 0; i < 11; i++) begin
      drive(0, 1, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
      chk($sformatf("halted%0d_step", i), 32'(bus.o_step), 0);
      chk($sformatf("halted%0d_str", i), 32'(strobes()), 0);
      chk($sformatf("halted%0d_hlt", i), 32'(bus.o_hlt), 1);
      tick();
    end
    drive(1, 1, 15, 0, 0); chk("hlt_rst_hlt", 32'(bus.o_hlt), 0); tick();
    drive(0, 0, 2, 0, 0);
    chk("unhalt_step", 32'(bus.o_step), 0);
    chk("unhalt_str", 32'(strobes()), 32'(CO | MI));
    chk("unhalt_hlt", 32'(bus.o_hlt), 0);
    clke = 1; tick();
    drive(0, 0, 2, 0, 0); chk("clke_a", 32'(bus.o_step), 1); tick();
    drive(0, 0, 2, 0, 0); chk("clke_b", 32'(bus.o_step), 1); tick();
    drive(0, 1, 2, 0, 0); chk("clke_c", 32'(bus.o_step), 1); tick();
    drive(0, 1, 2, 0, 0); chk("clke_d", 32'(bus.o_step), 2); tick();
    m_step = 2; m_halt = 0;
    drive(1, 1, 0, 0, 0); tick();
    for (int s = 0; s < 5; s++) begin
      drive(0, 0, 0, 0, 0);
      nop_str[s] = micro(0, s, 0, 0);
      chk($sformatf("nop_t%0d", s), 32'(strobes()), 32'(nop_str[s]));
      for (int op = 0; op < 16; op++) begin
        drive(0, 0, 4'(op), 1'($urandom), 1'($urandom));
        model_check($sformatf("sweep_op%0d_t%0d", op, s));
        if (op >= 9 && op <= 13) chk($sformatf("sweep_nop%0d_t%0d", op, s), 32'(strobes()), 32'(nop_str[s]));
      end
      drive(0, 1, 0, 0, 0); tick();
    end
    drive(1, 1, 0, 0, 0); tick();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
      model_check($sformatf("rnd%0d", i));
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
